// File: rtl/vi_mem_pkg.sv
// vi_mem_pkg: shared widths and state/source encodings for the main-memory responder.
package vi_mem_pkg;
   localparam int ADDR_W = 20;
   localparam int LINE_W = 128;
   localparam int LINE_OFF_W = 4;
   typedef enum logic [1:0] {IDLE, WAIT, RESP} mem_state_t;
   typedef enum logic {SRC_I, SRC_D} mem_src_t;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: icache/dcache grant; MEM_RR_ARB_EN selects round-robin, otherwise dcache has priority.
module mem_arbiter
   import vi_mem_pkg::*;
(
   input  logic     clk,
   input  logic     rst,
   input  logic     i_rqst,
   input  logic     d_rqst,
   input  logic     accept,
   output mem_src_t grant
);
`ifdef MEM_RR_ARB_EN
   mem_src_t last;
   always_ff @(posedge clk)
      if (rst) last <= SRC_I;
      else if (accept) last <= grant;
   // on a tie the port that was not served last goes first
   assign grant = (i_rqst && d_rqst) ? (last == SRC_I ? SRC_D : SRC_I) : (d_rqst ? SRC_D : SRC_I);
`else
   logic unused;
   assign unused = ^{clk, rst, i_rqst, accept};
   assign grant = d_rqst ? SRC_D : SRC_I;
`endif
endmodule

// File: rtl/mem_responder.sv
// mem_responder: fixed-latency line memory serving icache fills and dcache fills/write-backs.
// Define MEM_RR_ARB_EN for round-robin arbitration instead of fixed dcache priority.
module mem_responder
   import vi_mem_pkg::*;
#(
   parameter int MEM_LINES = 4096,
   parameter int LATENCY   = 5
) (
   input  logic              clk_i,
   input  logic              rsn_i,
   input  logic              i_rqst_i,
   input  logic [ADDR_W-1:0] i_addr_i,
   output logic              i_mem_ready_o,
   output logic [LINE_W-1:0] i_mem_data_o,
   output logic [ADDR_W-1:0] i_mem_addr_o,
   input  logic              d_rqst_i,
   input  logic              d_write_i,
   input  logic [ADDR_W-1:0] d_addr_i,
   input  logic [LINE_W-1:0] d_wdata_i,
   output logic              d_mem_ready_o,
   output logic [LINE_W-1:0] d_mem_data_o,
   output logic [ADDR_W-1:0] d_mem_addr_o,
   output logic              busy_o
);
   localparam int IDX_W = $clog2(MEM_LINES);
   mem_state_t        state;
   mem_src_t          grant, cap_src;
   logic [7:0]        cnt;
   logic [ADDR_W-1:0] cap_addr;
   logic              cap_write;
   logic [LINE_W-1:0] cap_wdata;
   logic [LINE_W-1:0] mem [MEM_LINES];
   logic [IDX_W-1:0]  idx;
   logic              accept;
   logic              unused;
   assign accept = state == IDLE && (i_rqst_i || d_rqst_i);
   assign idx    = cap_addr[IDX_W+LINE_OFF_W-1:LINE_OFF_W];
   assign unused = ^{i_addr_i[LINE_OFF_W-1:0], d_addr_i[LINE_OFF_W-1:0]};
   mem_arbiter u_arb (
      .clk    (clk_i),
      .rst    (rsn_i),
      .i_rqst (i_rqst_i),
      .d_rqst (d_rqst_i),
      .accept (accept),
      .grant  (grant)
   );
   always_ff @(posedge clk_i) begin
      if (rsn_i) begin
         state         <= IDLE;
         cnt           <= '0;
         cap_src       <= SRC_I;
         cap_addr      <= '0;
         cap_write     <= 1'b0;
         cap_wdata     <= '0;
         i_mem_ready_o <= 1'b0;
         i_mem_data_o  <= '0;
         i_mem_addr_o  <= '0;
         d_mem_ready_o <= 1'b0;
         d_mem_data_o  <= '0;
         d_mem_addr_o  <= '0;
         busy_o        <= 1'b0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               state     <= WAIT;
               cnt       <= 8'(LATENCY - 1);
               cap_src   <= grant;
               cap_addr  <= grant == SRC_D ? {d_addr_i[ADDR_W-1:LINE_OFF_W], {LINE_OFF_W{1'b0}}}
                                             : {i_addr_i[ADDR_W-1:LINE_OFF_W], {LINE_OFF_W{1'b0}}};
               cap_write <= grant == SRC_D && d_write_i;
               cap_wdata <= d_wdata_i;
               busy_o    <= 1'b1;
            end
            WAIT: begin
               cnt <= cnt - 1'b1;
               // outputs are registered, so the RESP-cycle values are loaded on entry to RESP
               if (cnt == 8'd1) begin
                  state <= RESP;
                  if (cap_src == SRC_I) begin
                     i_mem_ready_o <= 1'b1;
                     i_mem_addr_o  <= cap_addr;
                     i_mem_data_o  <= mem[idx];
                  end else begin
                     d_mem_ready_o <= 1'b1;
                     d_mem_addr_o  <= cap_addr;
                     d_mem_data_o  <= cap_write ? '0 : mem[idx];
                  end
               end
            end
            default: begin
               state         <= IDLE;
               i_mem_ready_o <= 1'b0;
               d_mem_ready_o <= 1'b0;
               busy_o        <= 1'b0;
            end
         endcase
      end
   end
   always_ff @(posedge clk_i)
      if (!rsn_i && state == RESP && cap_write) mem[idx] <= cap_wdata;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed checks of latency, data, arbitration, aliasing and reset abort.
module tb_mem_responder;
   import vi_mem_pkg::*;
   localparam int LAT = 5;
   logic              clk = 1'b0;
   logic              rsn_i = 1'b1;
   logic              i_rqst_i = 1'b0;
   logic [ADDR_W-1:0] i_addr_i = '0;
   logic              i_mem_ready_o;
   logic [LINE_W-1:0] i_mem_data_o;
   logic [ADDR_W-1:0] i_mem_addr_o;
   logic              d_rqst_i = 1'b0;
   logic              d_write_i = 1'b0;
   logic [ADDR_W-1:0] d_addr_i = '0;
   logic [LINE_W-1:0] d_wdata_i = '0;
   logic              d_mem_ready_o;
   logic [LINE_W-1:0] d_mem_data_o;
   logic [ADDR_W-1:0] d_mem_addr_o;
   logic              busy_o;
   int errors = 0;
   int checks = 0;
   localparam logic [LINE_W-1:0] BEEF = 128'h0123_4567_89AB_CDEF_0011_2233_DEAD_BEEF;
   localparam logic [LINE_W-1:0] A5   = {16{8'hA5}};
   localparam logic [LINE_W-1:0] ALI  = 128'hCAFE_F00D_1234_5678_9ABC_DEF0_5555_AAAA;
   localparam logic [LINE_W-1:0] OLD  = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
   localparam logic [LINE_W-1:0] NEW  = 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000;

   mem_responder #(.MEM_LINES(4096), .LATENCY(LAT)) dut (
      .clk_i(clk), .rsn_i(rsn_i),
      .i_rqst_i(i_rqst_i), .i_addr_i(i_addr_i),
      .i_mem_ready_o(i_mem_ready_o), .i_mem_data_o(i_mem_data_o), .i_mem_addr_o(i_mem_addr_o),
      .d_rqst_i(d_rqst_i), .d_write_i(d_write_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
      .d_mem_ready_o(d_mem_ready_o), .d_mem_data_o(d_mem_data_o), .d_mem_addr_o(d_mem_addr_o),
      .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, ".ctl"}, {125'd0, i_mem_ready_o, d_mem_ready_o, busy_o}, '0);
      check({tag, ".i_data"}, i_mem_data_o, '0);
      check({tag, ".d_data"}, d_mem_data_o, '0);
      check({tag, ".addrs"}, {88'd0, i_mem_addr_o, d_mem_addr_o}, '0);
   endtask

   task automatic txn(input string tag, input bit is_d, input bit wr, input logic [ADDR_W-1:0] addr,
                      input logic [LINE_W-1:0] wd, input logic [LINE_W-1:0] exp);
      int lat;
      logic busy_ok, other;
      @(negedge clk);
      if (is_d) begin
         d_rqst_i = 1'b1; d_write_i = wr; d_addr_i = addr; d_wdata_i = wd;
      end else begin
         i_rqst_i = 1'b1; i_addr_i = addr;
      end
      lat = 0; busy_ok = 1'b1; other = 1'b0;
      for (int k = 1; k <= 20 && lat == 0; k++) begin
         @(negedge clk);
         busy_ok &= busy_o;
         other |= is_d ? i_mem_ready_o : d_mem_ready_o;
         if (is_d ? d_mem_ready_o : i_mem_ready_o) lat = k;
      end
      i_rqst_i = 1'b0; d_rqst_i = 1'b0; d_write_i = 1'b0;
      check({tag, ".lat"}, LINE_W'(lat), LINE_W'(LAT));
      check({tag, ".busy"}, LINE_W'(busy_ok), 1);
      check({tag, ".other_rdy"}, LINE_W'(other), 0);
      check({tag, ".addr"}, LINE_W'(is_d ? d_mem_addr_o : i_mem_addr_o), LINE_W'({addr[ADDR_W-1:4], 4'h0}));
      check({tag, ".data"}, is_d ? d_mem_data_o : i_mem_data_o, exp);
      @(negedge clk);
      check({tag, ".after"}, {125'd0, i_mem_ready_o, d_mem_ready_o, busy_o}, '0);
   endtask

   task automatic tie(input string tag, input bit d_first, input logic [ADDR_W-1:0] ia,
                      input logic [LINE_W-1:0] iexp, input logic [ADDR_W-1:0] da, input logic [LINE_W-1:0] dexp);
      int ti, td;
      @(negedge clk);
      i_rqst_i = 1'b1; i_addr_i = ia;
      d_rqst_i = 1'b1; d_write_i = 1'b0; d_addr_i = da;
      ti = 0; td = 0;
      for (int k = 1; k <= 30 && (ti == 0 || td == 0); k++) begin
         @(negedge clk);
         if (i_mem_ready_o) begin
            ti = k; i_rqst_i = 1'b0;
            check({tag, ".i_data"}, i_mem_data_o, iexp);
         end
         if (d_mem_ready_o) begin
            td = k; d_rqst_i = 1'b0;
            check({tag, ".d_data"}, d_mem_data_o, dexp);
         end
      end
      i_rqst_i = 1'b0; d_rqst_i = 1'b0;
      check({tag, ".i_lat"}, LINE_W'(ti), LINE_W'(d_first ? 2 * LAT + 1 : LAT));
      check({tag, ".d_lat"}, LINE_W'(td), LINE_W'(d_first ? LAT : 2 * LAT + 1));
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rsn_i = 1'b1;
      @(negedge clk);
      rsn_i = 1'b0;
   endtask

   initial begin
      logic seen;
      repeat (2) @(negedge clk);
      check_zero("reset");
      rsn_i = 1'b0;
      txn("preload", 1'b1, 1'b1, 20'h00120, BEEF, '0);
      txn("ifill", 1'b0, 1'b0, 20'h0012C, '0, BEEF);
      txn("wb_a5", 1'b1, 1'b1, 20'h00340, A5, '0);
      txn("dfill_a5", 1'b1, 1'b0, 20'h00348, '0, A5);
      check("hold.i_data", i_mem_data_o, BEEF);
      check("hold.i_addr", LINE_W'(i_mem_addr_o), LINE_W'(20'h00120));
      do_reset();
      tie("tie1", 1'b1, 20'h0012C, BEEF, 20'h00344, A5);
      txn("alias_wr", 1'b1, 1'b1, 20'h10040, ALI, '0);
      txn("alias_rd", 1'b0, 1'b0, 20'h00040, '0, ALI);
      txn("lone_d", 1'b1, 1'b0, 20'h00120, '0, BEEF);
`ifdef MEM_RR_ARB_EN
      tie("tie2", 1'b0, 20'h00040, ALI, 20'h00340, A5);
`else
      tie("tie2", 1'b1, 20'h00040, ALI, 20'h00340, A5);
`endif
      txn("rst_old", 1'b1, 1'b1, 20'h00500, OLD, '0);
      @(negedge clk);
      d_rqst_i = 1'b1; d_write_i = 1'b1; d_addr_i = 20'h00500; d_wdata_i = NEW;
      repeat (2) @(negedge clk);
      check("rst.mid_busy", LINE_W'(busy_o), 1);
      rsn_i = 1'b1; d_rqst_i = 1'b0; d_write_i = 1'b0;
      @(negedge clk);
      rsn_i = 1'b0;
      check_zero("rst_abort");
      seen = 1'b0;
      repeat (10) begin
         @(negedge clk);
         seen |= i_mem_ready_o | d_mem_ready_o;
      end
      check("rst.no_pulse", LINE_W'(seen), 0);
      txn("rst_read", 1'b1, 1'b0, 20'h00500, '0, OLD);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
